slow_clk_monitor: RTL
=====================

# slow_clk_monitor

Receiving end of the divided slow clock. It samples an asynchronous slow square wave (e.g. the 1 Hz toggle output of the clock divider) in the fast `clkin` domain and converts each edge into a one-cycle tick. It measures every half period and reports lock or loss of the slow clock. Downstream logic consumes the ticks instead of clocking registers on the slow signal.

## Interface
Parameters:
- `HALF_PERIOD`, default 25000001: expected `clkin` cycles between consecutive slow edges.
- `TOL`, default 1000: allowed ± deviation of a measured half period.
- `LOCK_CNT`, default 4: consecutive good half periods required to assert `locked`.
- `CNT_W`, default 32: width of the measurement counter and of `half_period`.

Ports:
- `clkin`  input  1  fast system clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `slowin`  input  1  asynchronous slow clock to monitor.
- `rise_tick`  output  1  one-cycle pulse per detected rising edge of `slowin`.
- `fall_tick`  output  1  one-cycle pulse per detected falling edge of `slowin`.
- `locked`  output  1  high while the slow clock is within tolerance.
- `lost`  output  1  high after a missing edge (watchdog); see Configuration.
- `half_period`  output  CNT_W  last measured half period, in `clkin` cycles.

## Operation
- **Synchronizer:** `s1 <= slowin`, `s2 <= s1`, `s3 <= s2`.
  - Edge condition: `s2 != s3`.
  - Rise: `s2 = 1`. Fall: `s2 = 0`.
- **Ticks:** registered; high for exactly one cycle per edge. They are never both high in the same cycle.
- **Counter `cnt`:**
  - Loads 1 on the edge cycle; otherwise increments.
  - Saturates at 2^CNT_W−1 and never wraps.
  - The measured value is the distance in cycles between two consecutive ticks.
- **Good measurement:** `|m − HALF_PERIOD| <= TOL`. The comparison uses CNT_W+1-bit signed arithmetic, so it has no overflow.
- **States:**
  - ACQUIRE:
    - First edge → MEASURE.
    - The tick is emitted, the counter starts, and `half_period` is not updated.
  - MEASURE:
    - Each edge updates `half_period` to m.
    - Good edge: `good++`. When `good` reaches LOCK_CNT → LOCKED.
    - Bad edge: `good <= 0`.
  - LOCKED:
    - Each edge updates `half_period`.
    - Bad measurement → MEASURE with `good <= 0`; `locked` drops on the next cycle.
  - LOST (watchdog builds only):
    - Entered from MEASURE or LOCKED when `cnt` reaches `HALF_PERIOD+TOL+1` with no edge.
    - Next edge → MEASURE, `good <= 0`, `lost` clears. `half_period` is not updated on this edge, because the gap is invalid.
- **Outputs per state:** `locked` is high only in LOCKED. `lost` is high only in LOST.
- **Simultaneous events:** an edge in the same cycle as the timeout threshold is treated as an edge, so no LOST is entered.
- **Reset** (sync, takes priority over everything, including mid-measurement):
  - State ACQUIRE; `s1`, `s2`, `s3`, `cnt`, `good` cleared.
  - All outputs 0, `half_period` = 0.
  - If `slowin` is high through reset, the first rise after release is reported as `rise_tick` and is used only for alignment.

## Timing
- `slowin` sampled high at edge E0 (into `s1`) → `rise_tick` high during the cycle after edge E2. This is 3 cycles of latency, plus up to one cycle of metastability uncertainty.
- `half_period` and the state update in the same cycle the tick is asserted. `locked` and `lost` rise or fall together with that tick.
- Watchdog: `lost` asserts exactly `HALF_PERIOD+TOL+1` cycles after the last tick.
- Throughput: `slowin` must hold each level for at least 2 `clkin` cycles. Shorter pulses may be missed; this is not required behaviour.

## Configuration
- `SLOW_CLK_MONITOR_WDOG_EN` defined: timeout detection and the LOST state are present.
- Not defined:
  - No LOST state. `lost` is tied to 0.
  - A missing edge leaves the state unchanged until the next edge, whose (saturated) measurement is judged as bad.

## Test plan
All scenarios use `HALF_PERIOD=10`, `TOL=1`, `LOCK_CNT=4`, `CNT_W=8`.
- **Reset values:** hold `rst` for 3 cycles with `slowin=0` → all outputs 0 and `half_period=0`. Toggle `slowin` during reset → no ticks.
- **Latency and lock:** toggle `slowin` every 10 cycles → first `rise_tick` 3 cycles after the sampling edge; `half_period=10` from the 2nd tick; `locked=1` with the 5th tick; rise and fall ticks alternate.
- **Tolerance:** locked, then one half period of 12 → `half_period=12` and `locked` drops on that tick; 4 further periods of 9 → re-lock.
- **Watchdog (macro on):** locked, then hold `slowin` constant → `lost=1` exactly 12 cycles after the last tick and `locked=0`; resume toggling → `lost` clears on the first tick and `half_period` is unchanged.
- **Watchdog (macro off):** same stimulus → `lost` stays 0 and `locked` stays 1 until the next edge, which measures the gap (saturated at 255 if ≥ 255) and drops `locked`.
- **Reset mid-operation:** assert `rst` for 1 cycle while locked with `slowin=1` → next cycle all outputs 0; after release, one alignment `rise_tick` with no `half_period` update.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// Samples an asynchronous slow clock, emits one-cycle edge ticks, measures half periods and tracks lock.
// Define SLOW_CLK_MONITOR_WDOG_EN to add the missing-edge watchdog and the LOST state.
module slow_clk_monitor #(
   parameter int HALF_PERIOD = 25000001,
   parameter int TOL         = 1000,
   parameter int LOCK_CNT    = 4,
   parameter int CNT_W       = 32
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             slowin,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             locked,
   output logic             lost,
   output logic [CNT_W-1:0] half_period
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam logic signed [CNT_W:0] HP_S  = (CNT_W+1)'(HALF_PERIOD);
   localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
`ifdef SLOW_CLK_MONITOR_WDOG_EN
   localparam logic [CNT_W:0] WDOG_LIM = (CNT_W+1)'(HALF_PERIOD + TOL + 1);
`endif

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               s1_q, s2_q, s3_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [GOOD_W-1:0]  good_q, good_d;
   logic [CNT_W-1:0]   hp_q, hp_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               edge_det;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // One extra bit keeps |m - HALF_PERIOD| free of overflow for any m.
   function automatic logic is_good(input logic [CNT_W-1:0] m);
      logic signed [CNT_W:0] diff;
      logic signed [CNT_W:0] mag;
      diff = $signed({1'b0, m}) - HP_S;
      mag  = (diff < 0) ? -diff : diff;
      return mag <= TOL_S;
   endfunction

   assign edge_det = s2_q ^ s3_q;

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      hp_d    = hp_q;
      cnt_d   = edge_det ? CNT_W'(1) : sat_inc(cnt_q);
      rise_d  = edge_det & s2_q;
      fall_d  = edge_det & ~s2_q;

      case (state_q)
         ACQUIRE: begin
            if (edge_det) begin
               state_d = MEASURE;
               good_d  = '0;
            end
         end
         MEASURE: begin
            if (edge_det) begin
               hp_d = cnt_q;
               if (is_good(cnt_q)) begin
                  if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                     state_d = LOCKED;
                     good_d  = '0;
                  end else begin
                     good_d = good_q + 1'b1;
                  end
               end else begin
                  good_d = '0;
               end
            end
`ifdef SLOW_CLK_MONITOR_WDOG_EN
            else if ({1'b0, cnt_q} >= WDOG_LIM) begin
               state_d = LOST;
               good_d  = '0;
            end
`endif
         end
         LOCKED: begin
            if (edge_det) begin
               hp_d = cnt_q;
               if (!is_good(cnt_q)) begin
                  state_d = MEASURE;
                  good_d  = '0;
               end
            end
`ifdef SLOW_CLK_MONITOR_WDOG_EN
            else if ({1'b0, cnt_q} >= WDOG_LIM) begin
               state_d = LOST;
               good_d  = '0;
            end
`endif
         end
`ifdef SLOW_CLK_MONITOR_WDOG_EN
         LOST: begin
            // The gap that led here is meaningless, so half_period keeps its old value.
            if (edge_det) begin
               state_d = MEASURE;
               good_d  = '0;
            end
         end
`endif
         default: begin
            state_d = ACQUIRE;
            good_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state_q <= ACQUIRE;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s3_q    <= 1'b0;
         cnt_q   <= '0;
         good_q  <= '0;
         hp_q    <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= slowin;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         cnt_q   <= cnt_d;
         good_q  <= good_d;
         hp_q    <= hp_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign rise_tick   = rise_q;
   assign fall_tick   = fall_q;
   assign half_period = hp_q;
   assign locked      = (state_q == LOCKED);
`ifdef SLOW_CLK_MONITOR_WDOG_EN
   assign lost        = (state_q == LOST);
`else
   assign lost        = 1'b0;
`endif

endmodule
